// File: rtl/jk_excite_driver.sv
// Stimulus-side driver for a 2-bit JK state machine: turns a requested next
// state into J/K excitations, clocks two internal JK flops and checks the result.
module jk_excite_driver #(
   parameter logic        DC_FILL = 1'b0,
   parameter int unsigned CNT_W   = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [1:0]       req_state,
   input  logic             hold,
   output logic             ja,
   output logic             ka,
   output logic             jb,
   output logic             kb,
   output logic             A,
   output logic             B,
   output logic             z,
   output logic             done,
   output logic             ok,
   output logic [CNT_W-1:0] step_cnt,
   output logic [CNT_W-1:0] err_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      APPLY = 2'd1,
      CHECK = 2'd2
   } state_e;

   state_e           state_q;
   logic [1:0]       tgt_q;
   logic             ja_q, ka_q, jb_q, kb_q;
   logic             a_q, b_q;
   logic             done_q, ok_q;
   logic [CNT_W-1:0] step_q, err_q;

   logic             accept;
   logic [1:0]       exc_a_d, exc_b_d;
   logic             a_d, b_d;
   logic             hit_d;

   assign accept = req_valid && (state_q == IDLE);

   // Excitation table {J,K} from present Q and requested Q+; don't-cares filled.
   always_comb begin
      exc_a_d = 2'b00;
      exc_b_d = 2'b00;
      if (a_q) exc_a_d = {DC_FILL, ~req_state[1]};
      else     exc_a_d = {req_state[1], DC_FILL};
      if (b_q) exc_b_d = {DC_FILL, ~req_state[0]};
      else     exc_b_d = {req_state[0], DC_FILL};
   end

   // JK characteristic equation for both flops, plus the check against target.
   always_comb begin
      a_d   = (ja_q & ~a_q) | (~ka_q & a_q);
      b_d   = (jb_q & ~b_q) | (~kb_q & b_q);
      hit_d = ({a_d, b_d} == tgt_q);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         tgt_q   <= 2'b00;
         ja_q    <= 1'b0;
         ka_q    <= 1'b0;
         jb_q    <= 1'b0;
         kb_q    <= 1'b0;
         a_q     <= 1'b0;
         b_q     <= 1'b0;
         done_q  <= 1'b0;
         ok_q    <= 1'b0;
         step_q  <= '0;
         err_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               if (accept) begin
                  tgt_q         <= req_state;
                  {ja_q, ka_q}  <= exc_a_d;
                  {jb_q, kb_q}  <= exc_b_d;
                  state_q       <= APPLY;
               end
            end
            APPLY: begin
               // done/ok are registered here so they are visible during CHECK
               if (!hold) begin
                  a_q     <= a_d;
                  b_q     <= b_d;
                  done_q  <= 1'b1;
                  ok_q    <= hit_d;
                  if (step_q != CNT_MAX) step_q <= step_q + CNT_W'(1);
                  if (!hit_d && (err_q != CNT_MAX)) err_q <= err_q + CNT_W'(1);
                  state_q <= CHECK;
               end
            end
            CHECK: begin
               done_q  <= 1'b0;
               ja_q    <= 1'b0;
               ka_q    <= 1'b0;
               jb_q    <= 1'b0;
               kb_q    <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign req_ready = (state_q == IDLE);
   assign ja        = ja_q;
   assign ka        = ka_q;
   assign jb        = jb_q;
   assign kb        = kb_q;
   assign A         = a_q;
   assign B         = b_q;
   assign z         = a_q & ~b_q;
   assign done      = done_q;
   assign ok        = ok_q;
   assign step_cnt  = step_q;
   assign err_cnt   = err_q;

endmodule

// File: tb/tb_jk_excite_driver.sv
// Directed bench: two instances (DC_FILL=0/CNT_W=8 and DC_FILL=1/CNT_W=2)
// share one stimulus stream; expected values are hand-computed constants.
module tb_jk_excite_driver;

   logic       clk;
   logic       rst_n;
   logic       req_valid;
   logic [1:0] req_state;
   logic       hold;

   logic       rdy0, ja0, ka0, jb0, kb0, a0, b0, z0, done0, ok0;
   logic [7:0] step0, err0;
   logic       rdy1, ja1, ka1, jb1, kb1, a1, b1, z1, done1, ok1;
   logic [1:0] step1, err1;

   int tests_run;
   int tests_failed;

   jk_excite_driver #(.DC_FILL(1'b0), .CNT_W(8)) dut0 (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy0),
      .req_state(req_state), .hold(hold),
      .ja(ja0), .ka(ka0), .jb(jb0), .kb(kb0), .A(a0), .B(b0), .z(z0),
      .done(done0), .ok(ok0), .step_cnt(step0), .err_cnt(err0)
   );

   jk_excite_driver #(.DC_FILL(1'b1), .CNT_W(2)) dut1 (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy1),
      .req_state(req_state), .hold(hold),
      .ja(ja1), .ka(ka1), .jb(jb1), .kb(kb1), .A(a1), .B(b1), .z(z1),
      .done(done1), .ok(ok1), .step_cnt(step1), .err_cnt(err1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One back-to-back step: accept, apply, check. e0/e1 are {ja,ka,jb,kb}.
   task automatic do_step(input logic [1:0] t, input logic [3:0] e0, input logic [3:0] e1,
                          input logic [7:0] s0, input logic [1:0] s1, input logic zexp);
      req_state = t;
      req_valid = 1'b1;
      tick();
      chk("busy_ready0", 32'(rdy0), 32'd0);
      chk("exc0", 32'({ja0, ka0, jb0, kb0}), 32'(e0));
      chk("exc1", 32'({ja1, ka1, jb1, kb1}), 32'(e1));
      chk("apply_done0", 32'(done0), 32'd0);
      tick();
      chk("done0", 32'(done0), 32'd1);
      chk("done1", 32'(done1), 32'd1);
      chk("ab0", 32'({a0, b0}), 32'(t));
      chk("ab1", 32'({a1, b1}), 32'(t));
      chk("ok0", 32'(ok0), 32'd1);
      chk("ok1", 32'(ok1), 32'd1);
      chk("z0", 32'(z0), 32'(zexp));
      chk("step0", 32'(step0), 32'(s0));
      chk("step1", 32'(step1), 32'(s1));
      chk("err0", 32'(err0), 32'd0);
      chk("check_ready0", 32'(rdy0), 32'd0);
      tick();
      chk("done_pulse0", 32'(done0), 32'd0);
      chk("exc_clr0", 32'({ja0, ka0, jb0, kb0}), 32'd0);
      chk("exc_clr1", 32'({ja1, ka1, jb1, kb1}), 32'd0);
      chk("idle_ready0", 32'(rdy0), 32'd1);
      chk("ok_held0", 32'(ok0), 32'd1);
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      rst_n        = 1'b0;
      req_valid    = 1'b0;
      req_state    = 2'b00;
      hold         = 1'b0;

      // Reset state
      tick();
      chk("rst_ab0", 32'({a0, b0}), 32'd0);
      chk("rst_exc0", 32'({ja0, ka0, jb0, kb0}), 32'd0);
      chk("rst_done_ok0", 32'({done0, ok0}), 32'd0);
      chk("rst_cnt0", 32'({step0, err0}), 32'd0);
      chk("rst_cnt1", 32'({step1, err1}), 32'd0);
      rst_n = 1'b1;
      tick();
      chk("post_rst_ready0", 32'(rdy0), 32'd1);
      chk("post_rst_ready1", 32'(rdy1), 32'd1);

      // Back-to-back 01,10,11,00 with req_valid held high throughout
      do_step(2'b01, 4'b0010, 4'b0111, 8'd1, 2'd1, 1'b0);
      do_step(2'b10, 4'b1001, 4'b1111, 8'd2, 2'd2, 1'b1);
      do_step(2'b11, 4'b0010, 4'b1011, 8'd3, 2'd3, 1'b0);
      do_step(2'b00, 4'b0101, 4'b1111, 8'd4, 2'd3, 1'b0);
      chk("err1_after4", 32'(err1), 32'd0);

      // 00 -> 11
      do_step(2'b11, 4'b1010, 4'b1111, 8'd5, 2'd3, 1'b0);

      // 11 -> 00 with five hold cycles in APPLY
      req_state = 2'b00;
      req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      hold      = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("hold_done0", 32'(done0), 32'd0);
         chk("hold_ab0", 32'({a0, b0}), 32'd3);
         chk("hold_exc0", 32'({ja0, ka0, jb0, kb0}), 32'b0101);
         chk("hold_exc1", 32'({ja1, ka1, jb1, kb1}), 32'b1111);
         chk("hold_z0", 32'(z0), 32'd0);
      end
      hold = 1'b0;
      tick();
      chk("hold_rel_done0", 32'(done0), 32'd1);
      chk("hold_rel_ab0", 32'({a0, b0}), 32'd0);
      chk("hold_rel_ab1", 32'({a1, b1}), 32'd0);
      chk("hold_rel_ok1", 32'(ok1), 32'd1);
      chk("hold_rel_step0", 32'(step0), 32'd6);
      tick();
      chk("hold_end_ready0", 32'(rdy0), 32'd1);

      // Target equal to present state
      do_step(2'b00, 4'b0000, 4'b0101, 8'd7, 2'd3, 1'b0);
      chk("err0_final", 32'(err0), 32'd0);
      chk("err1_final", 32'(err1), 32'd0);

      // Reset in the middle of APPLY aborts the step
      req_state = 2'b11;
      req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      chk("pre_abort_exc0", 32'({ja0, ka0, jb0, kb0}), 32'b1010);
      #1 rst_n = 1'b0;
      #1;
      chk("abort_ab0", 32'({a0, b0}), 32'd0);
      chk("abort_exc0", 32'({ja0, ka0, jb0, kb0}), 32'd0);
      chk("abort_exc1", 32'({ja1, ka1, jb1, kb1}), 32'd0);
      chk("abort_done_ok0", 32'({done0, ok0}), 32'd0);
      chk("abort_step0", 32'(step0), 32'd0);
      chk("abort_step1", 32'(step1), 32'd0);
      tick();
      rst_n = 1'b1;
      tick();
      chk("abort_nodone0", 32'(done0), 32'd0);
      tick();
      chk("abort_nodone0_b", 32'(done0), 32'd0);
      chk("abort_step0_b", 32'(step0), 32'd0);
      chk("abort_ready0", 32'(rdy0), 32'd1);
      chk("abort_ab0_b", 32'({a0, b0}), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
